pcs_tx_seq_ctrl: RTL and testbench

- Sequencing controller for the 32-bit TX PCS datapath (encoder -> scrambler -> transceiver 64b/66b synchronous gearbox).
- Generates the gearbox sequence count, the per-cycle `pause` cadence, the block header phase and the scrambler `init_done`.
- Brings the datapath up only after the transceiver reports ready and a settle period has elapsed.
- Sits beside the PCS TX pipeline; its outputs fan out to the scrambler, the encoder, the MAC TX ready and the transceiver.

---
 rtl/pcs_pkg.sv | 26 ++
 rtl/gearbox_seq_counter.sv | 42 ++++
 rtl/pcs_tx_seq_ctrl.sv | 131 +++++++++++++
 tb/tb_pcs_tx_seq_ctrl.sv | 204 ++++++++++++++++++++
 4 files changed

// File: rtl/pcs_pkg.sv
// Shared PCS TX types and constants: sequencing FSM state encoding,
// datapath word width and the terminal gearbox sequence value.
package pcs_pkg;

  localparam int PCS_DATA_WIDTH  = 32;
  localparam int GEARBOX_SEQ_MAX = 32;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETTLE = 2'd1,
    ALIGN  = 2'd2,
    RUN    = 2'd3
  } tx_seq_state_t;

  // Next value of a wrapping sequence count that runs 0..max_v.
  function automatic logic [5:0] seq_next(input logic [5:0] seq, input logic [5:0] max_v);
    logic [5:0] nxt;
    if (seq == max_v) begin
      nxt = 6'd0;
    end else begin
      nxt = seq + 6'd1;
    end
    return nxt;
  endfunction

endpackage

// File: rtl/gearbox_seq_counter.sv
// Wrapping gearbox sequence counter (0..SEQ_MAX) with hold-at-zero, plus
// the pause-cycle and block-header-phase decodes derived from it.
module gearbox_seq_counter
  import pcs_pkg::*;
#(
  parameter int SEQ_MAX = GEARBOX_SEQ_MAX
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       hold,
  input  logic       active,
  input  logic       init_done,
  output logic [5:0] tx_seq,
  output logic       at_max,
  output logic       pause,
  output logic       header_phase
);

  localparam logic [5:0] MAX_V = 6'(SEQ_MAX);

  logic [5:0] seq_r;

  // Sequence register: parked at zero while held, otherwise counts and wraps.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      seq_r <= 6'd0;
    end else if (hold) begin
      seq_r <= 6'd0;
    end else begin
      seq_r <= seq_next(seq_r, MAX_V);
    end
  end

  // Decodes of the registered count; the pause slot carries no block word.
  always_comb begin
    tx_seq       = seq_r;
    at_max       = (seq_r == MAX_V);
    pause        = active && at_max;
    header_phase = !seq_r[0] && !at_max && init_done;
  end

endmodule

// File: rtl/pcs_tx_seq_ctrl.sv
// TX PCS sequencing controller: brings the encoder/scrambler/gearbox path
// up after transceiver ready plus a settle period, aligned to the gearbox
// sequence wrap. Optional block counter under macro PCS_TX_SEQ_STATS_EN.
module pcs_tx_seq_ctrl
  import pcs_pkg::*;
#(
  parameter int INIT_CYCLES = 16,
  parameter int SEQ_MAX     = GEARBOX_SEQ_MAX
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       xcvr_tx_ready,
  output logic [5:0] tx_seq,
  output logic       pause,
  output logic       header_phase,
  output logic       init_done,
  output logic       tx_data_ready,
  output logic [1:0] link_state
`ifdef PCS_TX_SEQ_STATS_EN
  ,
  output logic [31:0] block_count
`endif
);

  localparam int DATA_WIDTH = PCS_DATA_WIDTH;

  tx_seq_state_t         state_r;
  tx_seq_state_t         next_state_s;
  // Word-wide settle counter so any legal INIT_CYCLES fits.
  logic [DATA_WIDTH-1:0] settle_cnt_r;
  logic                  at_max_s;
  logic                  active_s;
  logic                  run_s;
  logic                  pause_s;
  logic                  header_phase_s;

  gearbox_seq_counter #(
    .SEQ_MAX(SEQ_MAX)
  ) u_seq (
    .clk         (clk),
    .reset_n     (reset_n),
    .hold        (!xcvr_tx_ready),
    .active      (active_s),
    .init_done   (run_s),
    .tx_seq      (tx_seq),
    .at_max      (at_max_s),
    .pause       (pause_s),
    .header_phase(header_phase_s)
  );

  // FSM state register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_r <= IDLE;
    end else begin
      state_r <= next_state_s;
    end
  end

  // Next-state logic; losing transceiver ready returns to IDLE from anywhere.
  always_comb begin
    next_state_s = state_r;
    if (!xcvr_tx_ready) begin
      next_state_s = IDLE;
    end else begin
      case (state_r)
        IDLE:    next_state_s = SETTLE;
        SETTLE: begin
          if (settle_cnt_r == DATA_WIDTH'(INIT_CYCLES - 1)) begin
            next_state_s = ALIGN;
          end else begin
            next_state_s = SETTLE;
          end
        end
        ALIGN: begin
          if (at_max_s) begin
            next_state_s = RUN;
          end else begin
            next_state_s = ALIGN;
          end
        end
        RUN:     next_state_s = RUN;
        default: next_state_s = IDLE;
      endcase
    end
  end

  // Settle counter: counts only while in SETTLE with ready held, else zero.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      settle_cnt_r <= '0;
    end else if ((state_r != SETTLE) || !xcvr_tx_ready) begin
      settle_cnt_r <= '0;
    end else begin
      settle_cnt_r <= settle_cnt_r + DATA_WIDTH'(1);
    end
  end

  // Output decodes from the state register and the sequence counter.
  always_comb begin
    run_s         = (state_r == RUN);
    active_s      = (state_r == ALIGN) || (state_r == RUN);
    pause         = pause_s;
    header_phase  = header_phase_s;
    init_done     = run_s;
    tx_data_ready = run_s && !pause_s;
    link_state    = state_r;
  end

`ifdef PCS_TX_SEQ_STATS_EN
  logic [31:0] block_count_r;

  // Block counter: one per header word in RUN, cleared on the way into IDLE.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      block_count_r <= 32'd0;
    end else if (next_state_s == IDLE) begin
      block_count_r <= 32'd0;
    end else if (run_s && header_phase_s) begin
      block_count_r <= block_count_r + 32'd1;
    end else begin
      block_count_r <= block_count_r;
    end
  end

  assign block_count = block_count_r;
`else
  // Statistics counter not built.
`endif

endmodule

// File: tb/tb_pcs_tx_seq_ctrl.sv
// Scoreboard bench for pcs_tx_seq_ctrl: three instances (INIT_CYCLES 16, 1
// and 31) share clock, reset and xcvr_tx_ready. Expected output vectors are
// derived from the cycle index since ready rose and queued before each edge.
module tb_pcs_tx_seq_ctrl;

  logic clk = 1'b0;
  logic reset_n;
  logic xcvr_tx_ready;

  logic [5:0] seq_a, seq_b, seq_c;
  logic       p_a, p_b, p_c, h_a, h_b, h_c, d_a, d_b, d_c, r_a, r_b, r_c;
  logic [1:0] st_a, st_b, st_c;
  logic [11:0] obs_a, obs_b, obs_c;
`ifdef PCS_TX_SEQ_STATS_EN
  logic [31:0] bc_a, bc_b, bc_c;
`endif

  int checks = 0;
  int errors = 0;

  typedef struct {
    int          n;
    logic [11:0] va;
    logic [11:0] vb;
    logic [11:0] vc;
  } exp_t;

  exp_t sb[$];

  always #5 clk = ~clk;

  pcs_tx_seq_ctrl #(.INIT_CYCLES(16), .SEQ_MAX(32)) dut_a (
    .clk(clk), .reset_n(reset_n), .xcvr_tx_ready(xcvr_tx_ready),
    .tx_seq(seq_a), .pause(p_a), .header_phase(h_a), .init_done(d_a),
    .tx_data_ready(r_a), .link_state(st_a)
`ifdef PCS_TX_SEQ_STATS_EN
    , .block_count(bc_a)
`endif
  );

  pcs_tx_seq_ctrl #(.INIT_CYCLES(1), .SEQ_MAX(32)) dut_b (
    .clk(clk), .reset_n(reset_n), .xcvr_tx_ready(xcvr_tx_ready),
    .tx_seq(seq_b), .pause(p_b), .header_phase(h_b), .init_done(d_b),
    .tx_data_ready(r_b), .link_state(st_b)
`ifdef PCS_TX_SEQ_STATS_EN
    , .block_count(bc_b)
`endif
  );

  pcs_tx_seq_ctrl #(.INIT_CYCLES(31), .SEQ_MAX(32)) dut_c (
    .clk(clk), .reset_n(reset_n), .xcvr_tx_ready(xcvr_tx_ready),
    .tx_seq(seq_c), .pause(p_c), .header_phase(h_c), .init_done(d_c),
    .tx_data_ready(r_c), .link_state(st_c)
`ifdef PCS_TX_SEQ_STATS_EN
    , .block_count(bc_c)
`endif
  );

  assign obs_a = {seq_a, p_a, h_a, d_a, r_a, st_a};
  assign obs_b = {seq_b, p_b, h_b, d_b, r_b, st_b};
  assign obs_c = {seq_c, p_c, h_c, d_c, r_c, st_c};

  // Expected {tx_seq,pause,header_phase,init_done,tx_data_ready,link_state}
  // n edges after ready rose from IDLE, for settle length ic (ic <= 31).
  function automatic logic [11:0] model(input int n, input int ic);
    logic [5:0] seq;
    logic [1:0] st;
    logic       p, h, d, r;
    seq = 6'(n % 33);
    if (n == 0)        st = 2'd0;
    else if (n <= ic)  st = 2'd1;
    else if (n <= 32)  st = 2'd2;
    else               st = 2'd3;
    p = (seq == 6'd32) && st[1];
    d = (st == 2'd3);
    h = !seq[0] && (seq != 6'd32) && d;
    r = d && !p;
    return {seq, p, h, d, r, st};
  endfunction

  task automatic test_reset();
    reset_n       = 1'b0;
    xcvr_tx_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (obs_a !== 12'd0) begin errors++; $display("FAIL reset_a got %h want %h", obs_a, 12'd0); end
    checks++;
    if (obs_b !== 12'd0) begin errors++; $display("FAIL reset_b got %h want %h", obs_b, 12'd0); end
    checks++;
    if (obs_c !== 12'd0) begin errors++; $display("FAIL reset_c got %h want %h", obs_c, 12'd0); end
  endtask

  // Entered at posedge+1 with all instances in IDLE, tx_seq 0, ready 1.
  task automatic test_bringup(input string tag);
    exp_t e;
    int   pauses = 0;
    int   headers = 0;
    int   rdy_low = 0;
    int   rdy_low_bad = 0;
    for (int n = 1; n <= 132; n++) begin
      sb.push_back('{n: n, va: model(n, 16), vb: model(n, 1), vc: model(n, 31)});
      @(posedge clk);
      #1;
      e = sb.pop_front();
      checks++;
      if (obs_a !== e.va) begin errors++; $display("FAIL %s_a n=%0d got %h want %h", tag, e.n, obs_a, e.va); end
      checks++;
      if (obs_b !== e.vb) begin errors++; $display("FAIL %s_b n=%0d got %h want %h", tag, e.n, obs_b, e.vb); end
      checks++;
      if (obs_c !== e.vc) begin errors++; $display("FAIL %s_c n=%0d got %h want %h", tag, e.n, obs_c, e.vc); end
      if (n >= 33 && n <= 98) begin
        if (p_a === 1'b1) pauses++;
        if (h_a === 1'b1) headers++;
        if (r_a !== 1'b1) begin
          rdy_low++;
          if (p_a !== 1'b1) rdy_low_bad++;
        end
      end
`ifdef PCS_TX_SEQ_STATS_EN
      if (n == 132) begin
        checks++;
        if (bc_a !== 32'd48) begin errors++; $display("FAIL %s_block_count got %0d want 48", tag, bc_a); end
      end
`endif
    end
    checks++;
    if (pauses != 2) begin errors++; $display("FAIL %s_pause_pulses got %0d want 2", tag, pauses); end
    checks++;
    if (headers != 32) begin errors++; $display("FAIL %s_header_count got %0d want 32", tag, headers); end
    checks++;
    if (rdy_low != 2 || rdy_low_bad != 0) begin
      errors++;
      $display("FAIL %s_ready_low got %0d (%0d off-pause) want 2 (0)", tag, rdy_low, rdy_low_bad);
    end
  endtask

  task automatic test_drop_rerise();
    exp_t e;
    bit   found = 1'b0;
    for (int i = 0; i < 40; i++) begin
      if (seq_a === 6'd10 && st_a === 2'd3) begin
        found = 1'b1;
        break;
      end
      @(posedge clk);
      #1;
    end
    checks++;
    if (!found) begin errors++; $display("FAIL drop_wait_seq10 got seq %0d want 10", seq_a); end
    xcvr_tx_ready = 1'b0;
    sb.push_back('{n: 0, va: 12'd0, vb: 12'd0, vc: 12'd0});
    @(posedge clk);
    #1;
    e = sb.pop_front();
    checks++;
    if (obs_a !== e.va) begin errors++; $display("FAIL drop_a got %h want %h", obs_a, e.va); end
    checks++;
    if (obs_b !== e.vb) begin errors++; $display("FAIL drop_b got %h want %h", obs_b, e.vb); end
    checks++;
    if (obs_c !== e.vc) begin errors++; $display("FAIL drop_c got %h want %h", obs_c, e.vc); end
`ifdef PCS_TX_SEQ_STATS_EN
    checks++;
    if (bc_a !== 32'd0) begin errors++; $display("FAIL drop_block_count got %0d want 0", bc_a); end
`endif
    // Ready returns in the very cycle the FSM sits freshly in IDLE.
    xcvr_tx_ready = 1'b1;
    test_bringup("rerise");
  endtask

  task automatic test_async_reset();
    @(posedge clk);
    #3;
    reset_n = 1'b0;
    #1;
    checks++;
    if (obs_a !== 12'd0) begin errors++; $display("FAIL async_reset_a got %h want %h", obs_a, 12'd0); end
    checks++;
    if (obs_b !== 12'd0) begin errors++; $display("FAIL async_reset_b got %h want %h", obs_b, 12'd0); end
    checks++;
    if (obs_c !== 12'd0) begin errors++; $display("FAIL async_reset_c got %h want %h", obs_c, 12'd0); end
`ifdef PCS_TX_SEQ_STATS_EN
    checks++;
    if (bc_a !== 32'd0) begin errors++; $display("FAIL async_reset_block_count got %0d want 0", bc_a); end
`endif
  endtask

  initial begin
    test_reset();
    reset_n = 1'b1;
    test_bringup("bringup");
    test_drop_rerise();
    test_async_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog timeout CHECKS %0d ERRORS %0d", checks, errors);
    $fatal(1, "watchdog");
  end

endmodule
